// File: rtl/commit_trace_if.sv
// Commit trace bundle: retirement/exception inputs plus the record stream to the consumer.
// Optional macro COMMIT_TRACE_TIMESTAMP_EN adds the out_tstamp_o record field.
interface commit_trace_if #(
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Retirement side
    logic [1:0]        commit_ack_i;
    logic [1:0][63:0]  commit_pc_i;
    logic [1:0][31:0]  commit_instr_i;
    logic [1:0][4:0]   waddr_i;
    logic [1:0][63:0]  wdata_i;
    logic [1:0]        we_gpr_i;
    logic [1:0]        we_fpr_i;
    logic [1:0]        priv_lvl_i;
    logic              debug_mode_i;
    logic              ex_valid_i;
    logic [63:0]       ex_cause_i;
    logic [63:0]       ex_tval_i;

    // Record stream side
    logic              out_ready_i;
    logic              out_valid_o;
    logic              out_kind_o;
    logic [63:0]       out_pc_o;
    logic [31:0]       out_instr_o;
    logic [4:0]        out_rd_o;
    logic              out_we_gpr_o;
    logic              out_we_fpr_o;
    logic [63:0]       out_data_o;
    logic [63:0]       out_cause_o;
    logic [1:0]        out_priv_o;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [63:0]       out_tstamp_o;
`endif

    // Status
    logic [CNT_W-1:0]  count_o;
    logic [15:0]       drop_cnt_o;
    logic              overflow_o;

    // Core/consumer view: drives retirement inputs and out_ready_i
    modport master (
        output commit_ack_i, commit_pc_i, commit_instr_i, waddr_i, wdata_i,
               we_gpr_i, we_fpr_i, priv_lvl_i, debug_mode_i,
               ex_valid_i, ex_cause_i, ex_tval_i, out_ready_i,
        input  out_valid_o, out_kind_o, out_pc_o, out_instr_o, out_rd_o,
               out_we_gpr_o, out_we_fpr_o, out_data_o, out_cause_o, out_priv_o,
`ifdef COMMIT_TRACE_TIMESTAMP_EN
               out_tstamp_o,
`endif
               count_o, drop_cnt_o, overflow_o
    );

    // Trace buffer view
    modport slave (
        input  commit_ack_i, commit_pc_i, commit_instr_i, waddr_i, wdata_i,
               we_gpr_i, we_fpr_i, priv_lvl_i, debug_mode_i,
               ex_valid_i, ex_cause_i, ex_tval_i, out_ready_i,
        output out_valid_o, out_kind_o, out_pc_o, out_instr_o, out_rd_o,
               out_we_gpr_o, out_we_fpr_o, out_data_o, out_cause_o, out_priv_o,
`ifdef COMMIT_TRACE_TIMESTAMP_EN
               out_tstamp_o,
`endif
               count_o, drop_cnt_o, overflow_o
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: collects up to three ordered records per cycle (port-0 retire,
// port-1 retire, exception) into a DEPTH-entry FIFO. A group that does not fit in the
// free space seen at the start of the cycle is dropped whole and counted.
// Optional macro COMMIT_TRACE_TIMESTAMP_EN stores a free-running cycle stamp per record.
module commit_trace_buffer #(
    parameter int DEPTH = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    commit_trace_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic        kind;
        logic [63:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        we_gpr;
        logic        we_fpr;
        logic [63:0] data;
        logic [63:0] cause;
        logic [1:0]  priv;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        logic [63:0] tstamp;
`endif
    } rec_t;

    rec_t              mem_r [DEPTH];
    logic [PTR_W-1:0]  wptr_r;
    logic [PTR_W-1:0]  rptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [15:0]       drop_r;
    logic              ovf_r;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [63:0]       tstamp_r;
`endif

    rec_t              port_rec_s [2];
    rec_t              exc_rec_s;
    rec_t              grp_s [3];
    rec_t              head_s;
    logic [1:0]        grp_n_s;
    logic              ex_take_s;
    logic [CNT_W-1:0]  free_s;
    logic              fit_s;
    logic              wr_s;
    logic              pop_s;
    logic [16:0]       drop_sum_s;

    // A breakpoint taken while in debug mode is a debugger event, not a trace record
    always_comb begin
        ex_take_s = bus.ex_valid_i && !(bus.debug_mode_i && (bus.ex_cause_i == 64'd3));
    end

    // Candidate records for both retire ports and the exception
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            port_rec_s[p]        = '0;
            port_rec_s[p].kind   = 1'b0;
            port_rec_s[p].pc     = bus.commit_pc_i[p];
            port_rec_s[p].instr  = bus.commit_instr_i[p];
            port_rec_s[p].rd     = bus.waddr_i[p];
            port_rec_s[p].we_gpr = bus.we_gpr_i[p] && (bus.waddr_i[p] != 5'd0);
            port_rec_s[p].we_fpr = bus.we_fpr_i[p];
            port_rec_s[p].data   = bus.wdata_i[p];
            port_rec_s[p].cause  = 64'd0;
            port_rec_s[p].priv   = bus.priv_lvl_i;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
            port_rec_s[p].tstamp = tstamp_r;
`endif
        end
        exc_rec_s        = '0;
        exc_rec_s.kind   = 1'b1;
        exc_rec_s.pc     = bus.commit_pc_i[0];
        exc_rec_s.instr  = bus.commit_instr_i[0];
        exc_rec_s.rd     = 5'd0;
        exc_rec_s.we_gpr = 1'b0;
        exc_rec_s.we_fpr = 1'b0;
        exc_rec_s.data   = bus.ex_tval_i;
        exc_rec_s.cause  = bus.ex_cause_i;
        exc_rec_s.priv   = bus.priv_lvl_i;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        exc_rec_s.tstamp = tstamp_r;
`endif
    end

    // Pack present records into consecutive group slots, oldest first
    always_comb begin
        grp_s[0] = '0;
        grp_s[1] = '0;
        grp_s[2] = '0;
        grp_n_s  = 2'd0;
        case ({ex_take_s, bus.commit_ack_i})
            3'b000: begin
                grp_n_s = 2'd0;
            end
            3'b001: begin
                grp_s[0] = port_rec_s[0];
                grp_n_s  = 2'd1;
            end
            3'b010: begin
                grp_s[0] = port_rec_s[1];
                grp_n_s  = 2'd1;
            end
            3'b011: begin
                grp_s[0] = port_rec_s[0];
                grp_s[1] = port_rec_s[1];
                grp_n_s  = 2'd2;
            end
            3'b100: begin
                grp_s[0] = exc_rec_s;
                grp_n_s  = 2'd1;
            end
            3'b101: begin
                grp_s[0] = port_rec_s[0];
                grp_s[1] = exc_rec_s;
                grp_n_s  = 2'd2;
            end
            3'b110: begin
                grp_s[0] = port_rec_s[1];
                grp_s[1] = exc_rec_s;
                grp_n_s  = 2'd2;
            end
            3'b111: begin
                grp_s[0] = port_rec_s[0];
                grp_s[1] = port_rec_s[1];
                grp_s[2] = exc_rec_s;
                grp_n_s  = 2'd3;
            end
            default: begin
                grp_n_s = 2'd0;
            end
        endcase
    end

    // Admission: free space is judged before this cycle's pop, so a pop never makes room
    always_comb begin
        free_s     = CNT_W'(DEPTH) - count_r;
        fit_s      = (CNT_W'(grp_n_s) <= free_s);
        wr_s       = fit_s && (grp_n_s != 2'd0);
        pop_s      = (count_r != {CNT_W{1'b0}}) && bus.out_ready_i;
        drop_sum_s = {1'b0, drop_r} + 17'(grp_n_s);
    end

    // Pointers, occupancy and drop accounting
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_r  <= {PTR_W{1'b0}};
            rptr_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            drop_r  <= 16'd0;
            ovf_r   <= 1'b0;
        end else begin
            if (wr_s) begin
                wptr_r <= wptr_r + PTR_W'(grp_n_s);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            count_r <= count_r + CNT_W'(wr_s ? grp_n_s : 2'd0) - CNT_W'(pop_s);
            if (!fit_s) begin
                drop_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
                ovf_r  <= 1'b1;
            end
        end
    end

`ifdef COMMIT_TRACE_TIMESTAMP_EN
    // Free-running cycle stamp shared by every record of a group
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tstamp_r <= 64'd0;
        end else begin
            tstamp_r <= tstamp_r + 64'd1;
        end
    end
`endif

    // Record storage; contents are left as-is across reset since count gates visibility
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 3; k++) begin
            if (wr_s && (2'(k) < grp_n_s)) begin
                mem_r[wptr_r + PTR_W'(k)] <= grp_s[k];
            end
        end
    end

    // Head entry and status come straight from registered state
    always_comb begin
        head_s            = mem_r[rptr_r];
        bus.out_valid_o   = (count_r != {CNT_W{1'b0}});
        bus.out_kind_o    = head_s.kind;
        bus.out_pc_o      = head_s.pc;
        bus.out_instr_o   = head_s.instr;
        bus.out_rd_o      = head_s.rd;
        bus.out_we_gpr_o  = head_s.we_gpr;
        bus.out_we_fpr_o  = head_s.we_fpr;
        bus.out_data_o    = head_s.data;
        bus.out_cause_o   = head_s.cause;
        bus.out_priv_o    = head_s.priv;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        bus.out_tstamp_o  = head_s.tstamp;
`endif
        bus.count_o       = count_r;
        bus.drop_cnt_o    = drop_r;
        bus.overflow_o    = ovf_r;
    end
endmodule
